mux_rr_sched: RTL
=================

# mux_rr_sched

Round-robin scheduler that shares one N:1 byte-wide mux output channel between NREQ requesters at packet granularity. It arbitrates among active requests, holds the mux select for a whole packet, and passes beats with a valid/ready handshake. It sits between the per-source framers of the Zigbee transmit path and the single downstream serializer.

## Interface
- NREQ, 8, number of requesters (power of two, 2..16)
- SEL_W, $clog2(NREQ), select width
- DATA_W, 8, beat width
- TIMEOUT, 16, stall cycles before forced release (used only with MUX_SCHED_TIMEOUT_EN)

- inClk  in  1  clock, rising edge
- inRstN  in  1  synchronous, active-low reset
- inReq  in  NREQ  per-requester valid beat available
- inLast  in  NREQ  per-requester beat is last of packet
- inData  in  NREQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- inReady  in  1  downstream accepts beat
- outValid  out  1  beat presented downstream
- outData  out  DATA_W  selected requester's beat
- outSel  out  SEL_W  registered mux select
- outGrant  out  NREQ  one-hot registered grant
- outAck  out  NREQ  beat of requester i accepted this cycle
- outBusy  out  1  packet in progress

## Operation
- Reset values: outGrant=0, outSel=0, outBusy=0, outValid=0, outAck=0, outData=0, state IDLE, last-winner pointer=NREQ-1 (requester 0 has first priority).
- States: IDLE, XFER.
- IDLE: if inReq!=0, winner = first set inReq bit scanning upward from pointer+1 modulo NREQ; register outSel=winner, outGrant=1<<winner, outBusy=1, go XFER. No beat accepted in IDLE.
- XFER: outValid=inReq[outSel]; outData=inData[outSel] when outValid, else 0; outAck[outSel]=outValid&inReady, other bits 0.
- Accepted beat with inLast[outSel]=1: pointer<=outSel, outGrant<=0, outBusy<=0, go IDLE.
- Requests from non-granted requesters are ignored during XFER; they never see outAck.
- Granted requester dropping inReq mid-packet: outValid=0, grant held (packet atomic).
- inLast on a beat not accepted (inReady=0) has no effect.
- Single-beat packet (inReq & inLast together) completes in one XFER cycle.
- outSel holds its last value in IDLE (mux stays stable).

## Timing
- Request visible before edge k in IDLE -> outGrant/outSel valid after edge k; first beat acceptable in the cycle after edge k (1-cycle arbitration latency).
- outValid, outData, outAck are combinational from inReq/inData/inReady and registered outSel; no extra latency in XFER.
- Last beat accepted at edge m -> IDLE during cycle after m -> next grant after edge m+1: exactly one bubble cycle between packets.
- Reset asserted at any edge: all outputs return to reset values after that edge; packet in flight abandoned, pointer reset.

## Configuration
- MUX_SCHED_TIMEOUT_EN defined: counter of consecutive XFER cycles with outValid=0 or inReady=0; at TIMEOUT count, release grant exactly as for a last beat (pointer<=outSel, go IDLE), counter cleared on any accepted beat and on entering XFER.
- Undefined: no counter, grant held indefinitely until last beat accepted.

## Structure
- Package mux_sched_pkg: state enum (IDLE, XFER), default NREQ/DATA_W/TIMEOUT constants.
- Sub-module rr_pick: combinational round-robin winner from inReq and pointer, outputs index and found flag.

## Test plan
- Reset: inRstN=0 for 2 cycles with inReq=8'hFF -> outGrant=0, outValid=0, outSel=0; release -> grant requester 0 next edge.
- Fairness: inReq=8'hFF, each packet 1 beat, inReady=1 -> grants 0,1,2,...,7,0 with one bubble between each.
- Packet hold: requester 3 sends 4 beats 8'h30..8'h33, inLast on 4th, requester 5 requesting -> outData 30,31,32,33 with outAck[3]; grant to 5 only after bubble.
- Backpressure: inReady=0 for 5 cycles mid-packet -> outData held, outAck=0, grant held; no beat lost or duplicated.
- Wrap: pointer=7, inReq=8'b0000_0101 -> winner 0; then pointer=0 -> winner 2.
- MUX_SCHED_TIMEOUT_EN, TIMEOUT=16: granted requester drops inReq -> grant released after 16 stall cycles; undefined build -> grant still held at cycle 100.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and default sizing for the packet-granular round-robin mux scheduler.
// Optional stall timeout is enabled with MUX_SCHED_TIMEOUT_EN.
package mux_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   localparam int NREQ_DEF    = 8;
   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit scanning upward from ptr+1,
// wrapping modulo NREQ (NREQ is a power of two, so SEL_W-bit addition wraps for free).
module rr_pick #(
   parameter int NREQ  = 8,
   parameter int SEL_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      idx   = ptr;
      found = 1'b0;
      cand  = ptr;
      // i == NREQ truncates to ptr itself, so the last winner has lowest priority
      for (int i = 1; i <= NREQ; i++) begin
         cand = ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one byte-wide mux output between NREQ requesters per packet.
// Define MUX_SCHED_TIMEOUT_EN to release a stalled grant after TIMEOUT stall cycles.
module mux_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int SEL_W   = $clog2(NREQ),
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   inClk,
   input  logic                   inRstN,
   input  logic [NREQ-1:0]        inReq,
   input  logic [NREQ-1:0]        inLast,
   input  logic [NREQ*DATA_W-1:0] inData,
   input  logic                   inReady,
   output logic                   outValid,
   output logic [DATA_W-1:0]      outData,
   output logic [SEL_W-1:0]       outSel,
   output logic [NREQ-1:0]        outGrant,
   output logic [NREQ-1:0]        outAck,
   output logic                   outBusy,
   output state_e                 outDbgState
);

   // Handshake: a beat moves when outValid && inReady in the same cycle; outValid
   // never waits on inReady, and only the granted requester can ever be acknowledged.

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic             accept;
   logic             release_pkt;

`ifdef MUX_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   rr_pick #(
      .NREQ  (NREQ),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req   (inReq),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // State register
   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         state_q <= IDLE;
         sel_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= SEL_W'(NREQ - 1);
`ifdef MUX_SCHED_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
`ifdef MUX_SCHED_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      ptr_d       = ptr_q;
      release_pkt = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               grant_d = NREQ'(1) << pick_idx;
               busy_d  = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            if (accept && inLast[sel_q]) begin
               release_pkt = 1'b1;
            end
`ifdef MUX_SCHED_TIMEOUT_EN
            // This cycle is the TIMEOUT-th consecutive stall
            if (!accept && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
               release_pkt = 1'b1;
            end
`endif
            if (release_pkt) begin
               ptr_d   = sel_q;
               grant_d = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MUX_SCHED_TIMEOUT_EN
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE || accept) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_W'(TIMEOUT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end
`endif

   // Output logic
   always_comb begin
      outValid    = (state_q == XFER) && inReq[sel_q];
      accept      = outValid && inReady;
      outData     = outValid ? inData[sel_q*DATA_W +: DATA_W] : '0;
      outAck      = '0;
      if (accept) begin
         outAck[sel_q] = 1'b1;
      end
      outSel      = sel_q;
      outGrant    = grant_q;
      outBusy     = busy_q;
      outDbgState = state_q;
   end

endmodule
